// File: rtl/verify_pkg.sv
// Shared types and default thresholds for the verifier result monitor.
package verify_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    WARN   = 2'b01,
    LOCKED = 2'b10
  } mon_state_e;

  localparam int DEF_LATENCY = 2;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_CONS_W  = 4;
  localparam int DEF_WARN_TH = 2;
  localparam int DEF_LOCK_TH = 4;

endpackage

// File: rtl/verify_result_monitor_sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/verify_result_monitor.sv
// Realigns the verifier sample strobe, tallies pass/fail and tracks consecutive failures.
// Optional per-cause failure counters when VERIFY_MON_CAUSE_EN is defined.
//
// state  | meaning
// NORMAL | fewer than WARN_TH consecutive failures
// WARN   | WARN_TH or more consecutive failures, below LOCK_TH
// LOCKED | LOCK_TH consecutive failures reached; only clear exits
module verify_result_monitor
  import verify_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int CONS_W  = DEF_CONS_W,
  parameter int WARN_TH = DEF_WARN_TH,
  parameter int LOCK_TH = DEF_LOCK_TH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             enc_match,
  input  logic             hash_match,
  input  logic             valid_flag,
  input  logic             clear,
  output logic             res_valid,
  output logic             res_ok,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [1:0]       state,
  output logic             alarm,
  output logic             locked,
  output logic             cons_err
`ifdef VERIFY_MON_CAUSE_EN
  ,
  output logic [CNT_W-1:0] enc_fail_cnt,
  output logic [CNT_W-1:0] hash_fail_cnt
`endif
);

  localparam logic [CONS_W-1:0] WARN_C = CONS_W'(WARN_TH);
  localparam logic [CONS_W-1:0] LOCK_C = CONS_W'(LOCK_TH);

  logic [LATENCY-1:0] dly;
  logic               v_al;
  logic               judge;
  logic               pass;
  logic               fail;
  logic [CONS_W-1:0]  cons_cnt;
  logic [CONS_W-1:0]  cons_inc;
  mon_state_e         state_q;
  mon_state_e         state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly <= '0;
    end else begin
      dly[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign v_al  = dly[LATENCY-1];
  assign judge = v_al & ~clear;
  assign pass  = judge & valid_flag;
  assign fail  = judge & ~valid_flag;

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (pass),
    .clr  (clear),
    .count(pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (fail),
    .clr  (clear),
    .count(fail_cnt)
  );

  // A pass breaks the failure run, so it clears the consecutive count.
  sat_counter #(.W(CONS_W)) u_cons_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (fail),
    .clr  (clear | pass),
    .count(cons_cnt)
  );

  // Count value after this cycle's failure, used to decide the transition now.
  assign cons_inc = (cons_cnt == '1) ? cons_cnt : cons_cnt + CONS_W'(1);

`ifdef VERIFY_MON_CAUSE_EN
  sat_counter #(.W(CNT_W)) u_enc_fail_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (judge & ~enc_match),
    .clr  (clear),
    .count(enc_fail_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hash_fail_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (judge & ~hash_match),
    .clr  (clear),
    .count(hash_fail_cnt)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = NORMAL;
    end else if (pass) begin
      if (state_q == WARN) begin
        state_d = NORMAL;
      end
    end else if (fail) begin
      if (cons_inc >= LOCK_C) begin
        state_d = LOCKED;
      end else if ((state_q == NORMAL) && (cons_inc >= WARN_C)) begin
        state_d = WARN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_ok    <= 1'b0;
      cons_err  <= 1'b0;
    end else begin
      res_valid <= judge;
      res_ok    <= pass;
      if (clear) begin
        cons_err <= 1'b0;
      end else if (judge && (valid_flag != (enc_match & hash_match))) begin
        cons_err <= 1'b1;
      end
    end
  end

  assign state  = state_q;
  assign alarm  = (state_q != NORMAL);
  assign locked = (state_q == LOCKED);

endmodule
